// File: rtl/sdr_wr_cmd_q.sv
// rtl/sdr_wr_cmd_q.sv - write command FIFO feeding the SDRAM single-write engine
// Splits queued linear addresses into bank/row/col and holds them until wr_done.
module sdr_wr_cmd_q #(
  parameter int DEPTH   = 8,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_done,
  input  logic                     usr_wr_valid,
  input  logic [23:0]              usr_wr_addr,
  output logic                     usr_wr_ready,
  output logic                     sdr_wr_req,
  output logic [1:0]               sdr_bank_addr,
  output logic [12:0]              sdr_row_addr,
  output logic [8:0]               sdr_col_addr,
  input  logic                     wr_done,
  input  logic                     ref_req,
  output logic                     ref_ack,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     err_timeout
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int TW   = $clog2(TIMEOUT + GAP_CYC + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_GAP} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            err_q, err_d;
  logic [23:0]     addr_q;
  logic [23:0]     mem [DEPTH];
  logic            push, pop;

  assign usr_wr_ready  = (cnt_q != CW'(DEPTH));
  assign push          = usr_wr_valid & usr_wr_ready;
  assign sdr_wr_req    = (state_q == S_REQ);
  assign ref_ack       = (state_q == S_IDLE) & ref_req;
  assign busy          = (state_q != S_IDLE);
  assign q_count       = cnt_q;
  assign err_timeout   = err_q;
  assign sdr_bank_addr = addr_q[23:22];
  assign sdr_row_addr  = addr_q[21:9];
  assign sdr_col_addr  = addr_q[8:0];

  // One timer serves both the WAIT timeout and the post-done gap.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (init_done && !ref_req && (cnt_q != '0)) begin
          pop     = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wr_done) begin
          tmr_d = '0;
          if (GAP_CYC > 0) state_d = S_GAP;
          else             state_d = S_IDLE;
        end else if (tmr_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_GAP: begin
        if (tmr_q == GAP_LAST) state_d = S_IDLE;
        else                   tmr_d   = tmr_q + TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        addr_q   <= mem[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= usr_wr_addr;
  end

endmodule
